// File: rtl/fifo_rx.sv
// Serial-to-byte receiver (MSB first) feeding a DEPTH-entry FIFO drained by zero-wait APB reads.
// Optional sync-word hunting before byte framing is enabled by defining RX_SYNC_HUNT_EN.
module fifo_rx #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned DATA_W    = 8,
  parameter logic [7:0]  SYNC_WORD = 8'hA7
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en_rx,
  input  logic                       bit_in,
  input  logic                       bit_en,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic                       mem_state,
  output logic [$clog2(DEPTH):0]     rx_count,
  output logic                       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DATA_W != 8 || $bits(SYNC_WORD) != DATA_W)
  begin : g_bad_cfg
    $error("fifo_rx: DEPTH must be a power of 2 >= 2 and DATA_W must be 8");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] sr_q, sr_d, sr_next;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              ovf_q, ovf_d, full_q, full_d;
  logic              xfer, pop, push_req, push;

`ifdef RX_SYNC_HUNT_EN
  typedef enum logic {HUNT, DATA} state_e;
  state_e state_q, state_d;
`endif

  always_comb begin
    xfer    = psel & penable;
    pop     = xfer & ~pwrite & (count_q != '0);
    pready  = xfer;
    pslverr = xfer & ~pop;
    prdata  = pop ? mem_q[rd_ptr_q] : '0;
  end

  always_comb begin
    sr_next  = {sr_q[DATA_W-2:0], bit_in};
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    push_req = 1'b0;
`ifdef RX_SYNC_HUNT_EN
    state_d  = state_q;
`endif
    if (!en_rx) begin
      sr_d     = '0;
      bitcnt_d = '0;
`ifdef RX_SYNC_HUNT_EN
      state_d  = HUNT;
`endif
    end else if (bit_en) begin
      sr_d = sr_next;
`ifdef RX_SYNC_HUNT_EN
      // While hunting, sr acts as a sliding window; the sync word itself is never pushed.
      if (state_q == HUNT) begin
        if (sr_next == SYNC_WORD) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end else
`endif
      begin
        if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
          push_req = 1'b1;
          bitcnt_d = '0;
        end else begin
          bitcnt_d = bitcnt_q + BIT_W'(1);
        end
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    push     = push_req & (~full_q | pop);
    ovf_d    = ovf_q | (push_req & full_q & ~pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d   = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sr_q     <= '0;
      bitcnt_q <= '0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
`ifdef RX_SYNC_HUNT_EN
      state_q  <= HUNT;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
`ifdef RX_SYNC_HUNT_EN
      state_q  <= state_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem_q[wr_ptr_q] <= sr_next;
    end
  end

  assign mem_state = full_q;
  assign rx_count  = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fifo_rx.sv
// Randomized bench for fifo_rx: a queue-based reference FIFO is fed by the stimulus and
// checked every falling edge against the DUT's APB responses and status outputs.
module tb_fifo_rx;
  localparam int unsigned DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0, en_rx = 1'b0, bit_in = 1'b0, bit_en = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] prdata;
  logic       pready, pslverr, mem_state, overflow;
  logic [6:0] rx_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model[$];
  logic       exp_ovf = 1'b0;
  logic       push_now = 1'b0;
  logic [7:0] push_val = '0;

  fifo_rx #(.DEPTH(DEPTH), .DATA_W(8), .SYNC_WORD(8'hA7)) dut (
    .clk(clk), .reset_n(reset_n), .en_rx(en_rx), .bit_in(bit_in), .bit_en(bit_en),
    .psel(psel), .penable(penable), .pwrite(pwrite), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .mem_state(mem_state), .rx_count(rx_count), .overflow(overflow)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT state with the model, then advance the model to the coming rising edge.
  // Inputs only change 1 time unit after a rising edge, so they are stable here.
  always @(negedge clk) begin
    check("rx_count", 32'(rx_count), 32'(model.size()));
    check("mem_state", 32'(mem_state), 32'(model.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("pready", 32'(pready), 32'(psel && penable));
    if (psel && penable) begin
      if (!pwrite && model.size() > 0) begin
        check("read_data", 32'(prdata), 32'(model[0]));
        check("read_slverr", 32'(pslverr), 32'd0);
      end else begin
        check("err_prdata", 32'(prdata), 32'd0);
        check("err_slverr", 32'(pslverr), 32'd1);
      end
    end else begin
      check("idle_prdata", 32'(prdata), 32'd0);
      check("idle_slverr", 32'(pslverr), 32'd0);
    end

    if (!reset_n) begin
      model.delete();
      exp_ovf = 1'b0;
    end else begin
      if (psel && penable && !pwrite && model.size() > 0) void'(model.pop_front());
      if (push_now) begin
        if (model.size() < DEPTH) model.push_back(push_val);
        else exp_ovf = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic last_push, input logic [7:0] v,
                          input int gap, input logic rd);
    bit_en = 1'b0;
    repeat (gap) tick();
    bit_in   = b;
    bit_en   = 1'b1;
    push_now = last_push;
    push_val = v;
    psel     = rd;
    penable  = rd;
    pwrite   = 1'b0;
    tick();
    bit_en   = 1'b0;
    push_now = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
  endtask

  // Byte goes out MSB first; rd_last overlaps an APB read with the final bit.
  task automatic send_byte(input logic [7:0] v, input logic do_push, input int gap,
                           input logic rd_last);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], do_push && (i == 0), v, gap, rd_last && (i == 0));
    end
  endtask

  task automatic apb_read(input int n);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    repeat (n) tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write();
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en_rx = 1'b0; bit_en = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic start_rx();
    en_rx = 1'b1;
    tick();
`ifdef RX_SYNC_HUNT_EN
    send_byte(8'hA7, 1'b0, 0, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0] partial;
    do_reset();
    start_rx();

    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b1, 3, 1'b0);
    apb_read(64);
    apb_read(1);
    apb_write();

    do_reset();
    start_rx();
    for (int i = 0; i < 65; i++) send_byte(8'(i * 3 + 1), 1'b1, 0, 1'b0);
    apb_read(64);
    apb_read(1);

    do_reset();
    start_rx();
    for (int i = 0; i < 64; i++) send_byte(8'(255 - i), 1'b1, 0, 1'b0);
    send_byte(8'h99, 1'b1, 0, 1'b1);
    apb_read(65);

    do_reset();
    en_rx = 1'b1;
    tick();
    partial = 8'hC3;
    for (int i = 7; i >= 3; i--) send_bit(partial[i], 1'b0, partial, 1, 1'b0);
    en_rx = 1'b0;
    tick();
`ifdef RX_SYNC_HUNT_EN
    en_rx = 1'b1;
    tick();
    send_byte(8'hFF, 1'b0, 0, 1'b0);
    send_byte(8'hA7, 1'b0, 0, 1'b0);
    send_byte(8'h12, 1'b1, 0, 1'b0);
`else
    start_rx();
    send_byte(8'h5A, 1'b1, 0, 1'b0);
`endif
    apb_read(2);

    do_reset();
    start_rx();
    repeat (150) begin
      case ($urandom_range(0, 3))
        0, 1: send_byte(8'($urandom), 1'b1, int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));
        2:    apb_read(int'($urandom_range(1, 4)));
        default: apb_write();
      endcase
    end
    apb_read(DEPTH + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
